rem_unit: RTL and testbench

// - Sequential signed-magnitude remainder unit for the ALU datapath; computes A rem B.
// - Operands are sign-magnitude: MSB = sign, low bits = magnitude.
// - Result sign follows the dividend (truncated remainder).
// - Produces negative, zero and divide-by-zero flags; one operation in flight at a time.

---
 rtl/rem_unit.sv | 179 +++++++++++++++++
 tb/tb_rem_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rem_unit.sv
// rem_unit: sequential sign-magnitude remainder (A rem B), restoring division
// one dividend bit per cycle. Optional floored-modulo result sign/magnitude
// selected by defining REM_FLOOR_MOD_EN; default build is truncated remainder.
module rem_unit #(
  parameter int unsigned MAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAG_W:0]   NumA,
  input  logic [MAG_W:0]   NumB,
  output logic             busy,
  output logic             done,
  output logic [MAG_W+1:0] Res,
  output logic             negF,
  output logic             zerF,
  output logic             DZF
);

  localparam int unsigned CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam int unsigned RES_W = MAG_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAG_W-1:0]   a_mag_q, a_mag_d;
  logic [MAG_W-1:0]   b_mag_q, b_mag_d;
  logic [MAG_W-1:0]   rem_q, rem_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               negf_q, negf_d;
  logic               zerf_q, zerf_d;
  logic               dzf_q, dzf_d;

  logic [MAG_W:0]     shift_rem;
  logic [MAG_W:0]     b_ext;
  logic [MAG_W:0]     trial;
  logic [MAG_W-1:0]   fin_mag;
  logic               fin_sign;

`ifndef REM_FLOOR_MOD_EN
  // Divisor sign only matters for floored modulo.
  logic unused_sign_b;
  assign unused_sign_b = sign_b_q;
`endif

  // Final magnitude/sign from the partial remainder, per remainder flavour.
  always_comb begin
    fin_mag  = rem_q;
    fin_sign = sign_a_q & (rem_q != '0);
`ifdef REM_FLOOR_MOD_EN
    if ((sign_a_q != sign_b_q) && (rem_q != '0)) begin
      fin_mag  = MAG_W'(b_mag_q - rem_q);
      fin_sign = sign_b_q;
    end else begin
      fin_mag  = rem_q;
      fin_sign = sign_b_q & (rem_q != '0);
    end
`endif
  end

  // Next-state and next-output logic for the IDLE -> CALC -> FIN sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    rem_d    = rem_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    negf_d   = negf_q;
    zerf_d   = zerf_q;
    dzf_d    = dzf_q;

    shift_rem = {rem_q, a_mag_q[cnt_q]};
    b_ext     = {1'b0, b_mag_q};
    trial     = shift_rem - b_ext;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_a_d = NumA[MAG_W];
          sign_b_d = NumB[MAG_W];
          a_mag_d  = NumA[MAG_W-1:0];
          b_mag_d  = NumB[MAG_W-1:0];
          dz_d     = (NumB[MAG_W-1:0] == '0);
          rem_d    = '0;
          cnt_d    = CNT_W'(MAG_W - 1);
          busy_d   = 1'b1;
          state_d  = (NumB[MAG_W-1:0] == '0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = (shift_rem >= b_ext) ? trial[MAG_W-1:0] : shift_rem[MAG_W-1:0];
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (dz_q) begin
          res_d  = '0;
          negf_d = 1'b0;
          zerf_d = 1'b0;
          dzf_d  = 1'b1;
        end else begin
          res_d  = {fin_sign, 1'b0, fin_mag};
          negf_d = fin_sign;
          zerf_d = (fin_mag == '0);
          dzf_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      rem_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      negf_q   <= 1'b0;
      zerf_q   <= 1'b0;
      dzf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      rem_q    <= rem_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      negf_q   <= negf_d;
      zerf_q   <= zerf_d;
      dzf_q    <= dzf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Res  = res_q;
  assign negF = negf_q;
  assign zerF = zerf_q;
  assign DZF  = dzf_q;

endmodule

// File: tb/tb_rem_unit.sv
// Directed bench for rem_unit (MAG_W=2); honours REM_FLOOR_MOD_EN if defined.
module tb_rem_unit;
  localparam int unsigned MAG_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [MAG_W:0]   NumA;
  logic [MAG_W:0]   NumB;
  logic             busy;
  logic             done;
  logic [MAG_W+1:0] Res;
  logic             negF;
  logic             zerF;
  logic             DZF;

  int checks = 0;
  int errors = 0;
  logic [MAG_W+1:0] last_res;

  always #5 clk = ~clk;

  rem_unit #(.MAG_W(MAG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .NumA(NumA), .NumB(NumB),
    .busy(busy), .done(done), .Res(Res), .negF(negF), .zerF(zerF), .DZF(DZF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done (bounded), checking Res holds its previous value meanwhile.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      chk({tag, " res_hold"}, 32'(Res), 32'(last_res));
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_res,
                            input logic e_neg, input logic e_zer, input logic e_dz);
    chk({tag, " Res"},  32'(Res),  32'(e_res));
    chk({tag, " negF"}, 32'(negF), 32'(e_neg));
    chk({tag, " zerF"}, 32'(zerF), 32'(e_zer));
    chk({tag, " DZF"},  32'(DZF),  32'(e_dz));
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] e_res, input logic e_neg,
                        input logic e_zer, input logic e_dz);
    @(negedge clk);
    NumA = a; NumB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(tag, e_dz ? 1 : MAG_W + 1);
    check_outs(tag, e_res, e_neg, e_zer, e_dz);
    chk({tag, " busy_clr"}, 32'(busy), 32'd0);
    last_res = e_res;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; NumA = '0; NumB = '0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    check_outs("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef REM_FLOOR_MOD_EN
    run_op("m3_p2", 3'b111, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0);
    run_op("p3_m2", 3'b011, 3'b110, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_op("p1_m3", 3'b001, 3'b111, 4'b1010, 1'b1, 1'b0, 1'b0);
`else
    run_op("m3_p2", 3'b111, 3'b010, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_op("p3_m2", 3'b011, 3'b110, 4'b0001, 1'b0, 1'b0, 1'b0);
    run_op("p1_m3", 3'b001, 3'b111, 4'b0001, 1'b0, 1'b0, 1'b0);
`endif
    run_op("m2_p1", 3'b110, 3'b001, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_op("p2_p3", 3'b010, 3'b011, 4'b0010, 1'b0, 1'b0, 1'b0);
    run_op("m1_m3", 3'b101, 3'b111, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_op("p3_p3", 3'b011, 3'b011, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_op("dz_p0", 3'b101, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("negz_a", 3'b100, 3'b010, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_op("dz_m0", 3'b101, 3'b100, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("p3_p2", 3'b011, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0);

    // Second start while busy must be dropped.
    @(negedge clk);
    NumA = 3'b111; NumB = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    NumA = 3'b011; NumB = 3'b001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_drop", MAG_W);
`ifdef REM_FLOOR_MOD_EN
    check_outs("busy_drop", 4'b0001, 1'b0, 1'b0, 1'b0);
    last_res = 4'b0001;
`else
    check_outs("busy_drop", 4'b1001, 1'b1, 1'b0, 1'b0);
    last_res = 4'b1001;
`endif
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk("busy_drop no_done", 32'(done), 32'd0);
    end
    chk("busy_drop idle", 32'(busy), 32'd0);

    // Reset during CALC aborts with outputs cleared and no done.
    @(negedge clk);
    NumA = 3'b011; NumB = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    check_outs("abort", 4'b0000, 1'b0, 1'b0, 1'b0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      chk("abort no_done", 32'(done), 32'd0);
    end
    run_op("after_abort", 3'b011, 3'b010, 4'b0001, 1'b0, 1'b0, 1'b0);

    // Start presented in the FIN cycle is ignored.
    @(negedge clk);
    NumA = 3'b010; NumB = 3'b011; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("fin_start busy", 32'(busy), 32'd1);
    @(negedge clk);
    NumA = 3'b101; NumB = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fin_start done", 32'(done), 32'd1);
    check_outs("fin_start", 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("fin_start idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("fin_start no_done", 32'(done), 32'd0);
    chk("fin_start no_dz", 32'(DZF), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
